subleq_mmio_bus: RTL and testbench



---
 rtl/subleq_mmio_bus.sv | 197 +++++++++++++++++++
 tb/tb_subleq_mmio_bus.sv | 418 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/subleq_mmio_bus.sv
// subleq_mmio_bus: registered MMIO bridge between subleq_cpu and memory, with
// per-channel output FIFOs, a stalling input handshake and EOF-driven halt.

// Single-channel output FIFO; head word is forced to zero while empty.
module subleq_mmio_fifo #(
    parameter int W     = 16,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         areset,
    input  logic         push,
    input  logic [W-1:0] wdata,
    input  logic         pop_ready,
    output logic         valid,
    output logic         full,
    output logic [W-1:0] rdata
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          pop;

    assign valid = (count != '0);
    assign full  = (count == (AW+1)'(DEPTH));
    assign pop   = pop_ready & valid;
    assign rdata = valid ? mem[rd_ptr] : '0;

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or negedge areset) begin
        if (!areset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage array, no reset needed: reads are gated by valid.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wdata;
    end
endmodule

module subleq_mmio_bus #(
    parameter int WORD_SIZE = 16,
    parameter int CHANNELS  = 2,
    parameter int OUT_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          areset,
    input  logic                          cpu_req,
    output logic                          cpu_ack,
    input  logic                          cpu_load,
    input  logic                          cpu_store,
    input  logic [WORD_SIZE-1:0]          cpu_addr,
    input  logic [WORD_SIZE-1:0]          cpu_wdata,
    output logic [WORD_SIZE-1:0]          cpu_rdata,
    output logic                          cpu_halt,
    output logic                          mem_req,
    input  logic                          mem_ack,
    output logic                          mem_load,
    output logic                          mem_store,
    output logic [WORD_SIZE-1:0]          mem_addr,
    output logic [WORD_SIZE-1:0]          mem_wdata,
    input  logic [WORD_SIZE-1:0]          mem_rdata,
    input  logic [CHANNELS-1:0]           in_valid,
    output logic [CHANNELS-1:0]           in_ready,
    input  logic [CHANNELS*WORD_SIZE-1:0] in_data,
    input  logic [CHANNELS-1:0]           in_eof,
    output logic [CHANNELS-1:0]           out_valid,
    input  logic [CHANNELS-1:0]           out_ready,
    output logic [CHANNELS*WORD_SIZE-1:0] out_data
);
    localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    typedef enum logic [2:0] {IDLE, MEM, IN_WAIT, OUT_WAIT, ACK, HALT} state_t;

    state_t                               state, state_d;
    logic [WORD_SIZE-1:0]                 addr_q, wdata_q, rdata_q;
    logic                                 load_q, store_q;
    logic [CW-1:0]                        chan_q;
    logic [CHANNELS-1:0]                  push, fifo_full;
    logic [CHANNELS-1:0][WORD_SIZE-1:0]   in_words, out_words;

    // Channel c lives at the top of the address space: addr = all-ones - c,
    // so the bitwise inverse of the address is the channel index.
    logic [WORD_SIZE-1:0] inv_addr;
    logic                 is_io, op_store, op_load;

    assign inv_addr = ~cpu_addr;
    assign is_io    = (inv_addr < WORD_SIZE'(CHANNELS));
    assign op_store = cpu_store;
    assign op_load  = cpu_load & ~cpu_store;   // store wins when both set

    assign in_words  = in_data;
    assign out_data  = out_words;
    assign cpu_rdata = rdata_q;
    assign cpu_halt  = (state == HALT);
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_load  = load_q;
    assign mem_store = store_q;

    // State register.
    always_ff @(posedge clk or negedge areset) begin
        if (!areset) state <= IDLE;
        else         state <= state_d;
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_d  = state;
        cpu_ack  = 1'b0;
        mem_req  = 1'b0;
        in_ready = '0;
        push     = '0;
        case (state)
            IDLE: begin
                if (cpu_req) begin
                    if (!op_store && !op_load) state_d = ACK;
                    else if (is_io)            state_d = op_load ? IN_WAIT : OUT_WAIT;
                    else                       state_d = MEM;
                end
            end
            MEM: begin
                mem_req = 1'b1;
                if (mem_ack) state_d = ACK;
            end
            IN_WAIT: begin
                if (in_valid[chan_q]) begin
                    in_ready[chan_q] = 1'b1;
                    state_d          = ACK;
                end else if (in_eof[chan_q]) begin
                    state_d = HALT;
                end
            end
            OUT_WAIT: begin
                // A pop on the same channel this cycle frees the slot we need.
                if (!fifo_full[chan_q] || out_ready[chan_q]) begin
                    push[chan_q] = 1'b1;
                    state_d      = ACK;
                end
            end
            ACK: begin
                cpu_ack = 1'b1;
                state_d = IDLE;
            end
            HALT:    state_d = HALT;
            default: state_d = IDLE;
        endcase
    end

    // Request capture and load-data return register.
    always_ff @(posedge clk or negedge areset) begin
        if (!areset) begin
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            load_q  <= 1'b0;
            store_q <= 1'b0;
            chan_q  <= '0;
        end else begin
            if (state == IDLE && cpu_req) begin
                addr_q  <= cpu_addr;
                wdata_q <= cpu_wdata;
                load_q  <= op_load;
                store_q <= op_store;
                chan_q  <= inv_addr[CW-1:0];
            end
            if (state == MEM && mem_ack && load_q) rdata_q <= mem_rdata;
            if (|in_ready)                         rdata_q <= in_words[chan_q];
        end
    end

    // One output FIFO per channel, all fed from the captured store data.
    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        subleq_mmio_fifo #(.W(WORD_SIZE), .DEPTH(OUT_DEPTH)) u_fifo (
            .clk      (clk),
            .areset   (areset),
            .push     (push[c]),
            .wdata    (wdata_q),
            .pop_ready(out_ready[c]),
            .valid    (out_valid[c]),
            .full     (fifo_full[c]),
            .rdata    (out_words[c])
        );
    end
endmodule

// File: tb/tb_subleq_mmio_bus.sv
// Self-checking bench for subleq_mmio_bus: directed scenarios plus a randomized
// mix, checked against queue/array reference models and latency rules.
module tb_subleq_mmio_bus;
    localparam int W  = 16;
    localparam int CH = 2;
    localparam int D  = 4;

    logic            clk = 0;
    logic            areset;
    logic            cpu_req, cpu_ack, cpu_load, cpu_store, cpu_halt;
    logic [W-1:0]    cpu_addr, cpu_wdata, cpu_rdata;
    logic            mem_req, mem_ack, mem_load, mem_store;
    logic [W-1:0]    mem_addr, mem_wdata, mem_rdata;
    logic [CH-1:0]   in_valid, in_ready, in_eof, out_valid, out_ready;
    logic [CH*W-1:0] in_data, out_data;

    subleq_mmio_bus #(.WORD_SIZE(W), .CHANNELS(CH), .OUT_DEPTH(D)) dut (
        .clk(clk), .areset(areset),
        .cpu_req(cpu_req), .cpu_ack(cpu_ack), .cpu_load(cpu_load), .cpu_store(cpu_store),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_halt(cpu_halt),
        .mem_req(mem_req), .mem_ack(mem_ack), .mem_load(mem_load), .mem_store(mem_store),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_eof(in_eof),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference models: expected FIFO contents per channel and memory image.
    logic [W-1:0] exp_q0[$];
    logic [W-1:0] exp_q1[$];
    logic [W-1:0] ref_mem [logic [W-1:0]];
    logic [W-1:0] env_mem [logic [W-1:0]];
    logic [W-1:0] stored_a[$];
    int           in_rdy_cnt [CH];
    int           mem_lat = 0;
    int           lat_cnt = 0;
    bit           rand_sink = 0;
    int           mon_sz;
    logic [W-1:0] mon_exp;

    function automatic void push_exp(input int c, input logic [W-1:0] v);
        if (c == 0) exp_q0.push_back(v);
        else        exp_q1.push_back(v);
    endfunction

    function automatic logic [W-1:0] pop_exp(input int c);
        if (c == 0) return exp_q0.pop_front();
        return exp_q1.pop_front();
    endfunction

    // Memory responder: acks mem_lat cycles after it first sees mem_req.
    initial begin
        mem_ack = 0; mem_rdata = '0;
        forever begin
            @(posedge clk); #1;
            if (!areset) begin
                mem_ack = 0; lat_cnt = 0;
            end else if (mem_ack) begin
                mem_ack = 0;
            end else if (mem_req) begin
                if (lat_cnt >= mem_lat) begin
                    mem_ack = 1; lat_cnt = 0;
                    if (mem_store) env_mem[mem_addr] = mem_wdata;
                    else if (mem_load) mem_rdata = env_mem.exists(mem_addr) ? env_mem[mem_addr] : '0;
                end else lat_cnt++;
            end else lat_cnt = 0;
        end
    end

    // Random output sink.
    initial forever begin
        @(posedge clk); #1;
        if (rand_sink) out_ready = CH'($urandom);
    end

    // Scoreboard / invariant monitor sampled on the falling edge.
    always @(negedge clk) begin
        if (areset === 1'b1) begin
            for (int c = 0; c < CH; c++) begin
                mon_sz = (c == 0) ? exp_q0.size() : exp_q1.size();
                n_checks++;
                if (out_valid[c] !== (mon_sz != 0)) begin
                    n_errors++;
                    $display("FAIL out_valid[%0d]: got %b expected %b", c, out_valid[c], mon_sz != 0);
                end
                if (out_valid[c] && out_ready[c] && mon_sz != 0) begin
                    mon_exp = pop_exp(c);
                    n_checks++;
                    if (out_data[c*W +: W] !== mon_exp) begin
                        n_errors++;
                        $display("FAIL out_data[%0d]: got %h expected %h", c, out_data[c*W +: W], mon_exp);
                    end
                end
                if (in_ready[c]) begin
                    in_rdy_cnt[c]++;
                    n_checks++;
                    if (!in_valid[c]) begin
                        n_errors++;
                        $display("FAIL in_ready_without_valid[%0d]: got 1 expected 0", c);
                    end
                end
            end
            if (mem_req) begin
                n_checks++;
                if (mem_addr >= W'(16'hFFFF - (CH - 1))) begin
                    n_errors++;
                    $display("FAIL mem_req_io_addr: got addr %h expected non-I/O", mem_addr);
                end
            end
        end
    end

    task automatic do_txn(input bit idle_first, input bit ld, input bit st, input logic [W-1:0] a,
                          input logic [W-1:0] wd, input int vch, input int dly, input logic [W-1:0] vdat,
                          input int max_cyc, output bit got, output int lat, output logic [W-1:0] rd);
        if (idle_first) begin
            cpu_req = 0; @(posedge clk); #1;
        end
        cpu_req = 1; cpu_load = ld; cpu_store = st; cpu_addr = a; cpu_wdata = wd;
        if (vch >= 0 && dly == 0) begin in_valid[vch] = 1; in_data[vch*W +: W] = vdat; end
        got = 0; lat = 0; rd = '0;
        while (!got && lat < max_cyc) begin
            @(posedge clk); #1; lat++;
            if (cpu_ack) begin
                got = 1; rd = cpu_rdata; cpu_req = 0;
                if (vch >= 0) in_valid[vch] = 0;
            end else if (vch >= 0 && lat == dly) begin
                in_valid[vch] = 1; in_data[vch*W +: W] = vdat;
            end
        end
    endtask

    task automatic apply_reset();
        cpu_req = 0; in_valid = '0; in_eof = '0; out_ready = '0; rand_sink = 0;
        areset = 0;
        exp_q0.delete(); exp_q1.delete();
        repeat (2) @(posedge clk);
        #1 areset = 1;
    endtask

    task automatic test_reset();
        areset = 0;
        repeat (3) @(posedge clk); #1;
        n_checks++;
        if ({cpu_ack, cpu_halt, mem_req, mem_load, mem_store} !== 5'b0) begin
            n_errors++; $display("FAIL reset_ctrl: got %b expected 00000", {cpu_ack, cpu_halt, mem_req, mem_load, mem_store});
        end
        n_checks++;
        if ({in_ready, out_valid} !== '0) begin
            n_errors++; $display("FAIL reset_chan: got %b expected 0", {in_ready, out_valid});
        end
        n_checks++;
        if ({cpu_rdata, mem_addr, mem_wdata, out_data} !== '0) begin
            n_errors++; $display("FAIL reset_data: got %h expected 0", {cpu_rdata, mem_addr, mem_wdata, out_data});
        end
        areset = 1;
        repeat (2) @(posedge clk); #1;
        n_checks++;
        if (cpu_ack !== 1'b0) begin n_errors++; $display("FAIL reset_idle_ack: got %b expected 0", cpu_ack); end
    endtask

    task automatic test_out_store();
        bit got; int lat; logic [W-1:0] rd;
        out_ready = '0;
        do_txn(1, 0, 1, 16'hFFFF, 16'h1234, -1, 0, '0, 10, got, lat, rd);
        if (got) push_exp(0, 16'h1234);
        n_checks++;
        if (!got || lat != 2) begin n_errors++; $display("FAIL store_ch0_lat: got ack=%0b lat=%0d expected 1/2", got, lat); end
        n_checks++;
        if (out_valid[0] !== 1'b1 || out_data[15:0] !== 16'h1234) begin
            n_errors++; $display("FAIL store_ch0_data: got v=%b d=%h expected 1/1234", out_valid[0], out_data[15:0]);
        end
        do_txn(1, 0, 1, 16'hFFFE, 16'h00AB, -1, 0, '0, 10, got, lat, rd);
        if (got) push_exp(1, 16'h00AB);
        n_checks++;
        if (!got || lat != 2) begin n_errors++; $display("FAIL store_ch1_lat: got ack=%0b lat=%0d expected 1/2", got, lat); end
        n_checks++;
        if (out_valid[1] !== 1'b1 || out_data[31:16] !== 16'h00AB) begin
            n_errors++; $display("FAIL store_ch1_data: got v=%b d=%h expected 1/00ab", out_valid[1], out_data[31:16]);
        end
        out_ready = '1; repeat (3) @(posedge clk); #1; out_ready = '0;
        n_checks++;
        if (out_valid !== '0) begin n_errors++; $display("FAIL store_drain: got %b expected 00", out_valid); end
    endtask

    task automatic test_fifo_full();
        bit got; int lat; logic [W-1:0] rd; logic [W-1:0] v [6];
        out_ready = '0;
        for (int i = 0; i < 6; i++) v[i] = W'($urandom);
        for (int i = 0; i < D; i++) begin
            do_txn(1, 0, 1, 16'hFFFF, v[i], -1, 0, '0, 10, got, lat, rd);
            if (got) push_exp(0, v[i]);
            n_checks++;
            if (!got || lat != 2) begin n_errors++; $display("FAIL fill_%0d: got ack=%0b lat=%0d expected 1/2", i, got, lat); end
        end
        do_txn(1, 0, 1, 16'hFFFF, v[D], -1, 0, '0, 6, got, lat, rd);
        n_checks++;
        if (got) begin n_errors++; push_exp(0, v[D]); $display("FAIL full_stall: got ack expected stall"); end
        out_ready[0] = 1; @(posedge clk); #1; out_ready[0] = 0;
        n_checks++;
        if (cpu_ack !== 1'b1) begin n_errors++; $display("FAIL full_pop_push_ack: got %b expected 1", cpu_ack); end
        else push_exp(0, v[D]);
        cpu_req = 0;
        do_txn(1, 0, 1, 16'hFFFF, v[5], -1, 0, '0, 10, got, lat, rd);
        n_checks++;
        if (got) begin n_errors++; push_exp(0, v[5]); $display("FAIL full_again_stall: got ack expected stall"); end
        out_ready[0] = 1;
        for (int i = 0; i < 12 && !cpu_ack; i++) begin @(posedge clk); #1; end
        if (cpu_ack) push_exp(0, v[5]);
        cpu_req = 0;
        repeat (8) @(posedge clk); #1; out_ready = '0;
        n_checks++;
        if (exp_q0.size() != 0 || out_valid[0] !== 1'b0) begin
            n_errors++; $display("FAIL wrap_drain: got left=%0d valid=%b expected 0/0", exp_q0.size(), out_valid[0]);
        end
    endtask

    task automatic test_in_load();
        bit got; int lat; logic [W-1:0] rd; logic [W-1:0] r;
        in_rdy_cnt[0] = 0; in_rdy_cnt[1] = 0;
        do_txn(1, 1, 0, 16'hFFFF, '0, 0, 3, 16'h0041, 20, got, lat, rd);
        n_checks++;
        if (!got || rd !== 16'h0041 || lat != 4) begin
            n_errors++; $display("FAIL in_load_ch0: got ack=%0b d=%h lat=%0d expected 1/0041/4", got, rd, lat);
        end
        n_checks++;
        if (in_rdy_cnt[0] != 1 || in_rdy_cnt[1] != 0) begin
            n_errors++; $display("FAIL in_ready_pulse: got %0d/%0d expected 1/0", in_rdy_cnt[0], in_rdy_cnt[1]);
        end
        r = W'($urandom);
        do_txn(1, 1, 0, 16'hFFFE, '0, 1, 0, r, 20, got, lat, rd);
        n_checks++;
        if (!got || rd !== r || lat != 2) begin
            n_errors++; $display("FAIL in_load_ch1: got ack=%0b d=%h lat=%0d expected 1/%h/2", got, rd, lat, r);
        end
    endtask

    task automatic test_mem_access();
        bit got; int lat; logic [W-1:0] rd; logic [W-1:0] r;
        env_mem[16'h0010] = 16'hBEEF; ref_mem[16'h0010] = 16'hBEEF; stored_a.push_back(16'h0010);
        mem_lat = 3;
        do_txn(1, 1, 0, 16'h0010, '0, -1, 0, '0, 20, got, lat, rd);
        n_checks++;
        if (!got || rd !== 16'hBEEF || lat != 5) begin
            n_errors++; $display("FAIL mem_load: got ack=%0b d=%h lat=%0d expected 1/beef/5", got, rd, lat);
        end
        // 0xFFFD is just below the channel window, so it must reach memory.
        mem_lat = 0; r = W'($urandom);
        do_txn(1, 0, 1, 16'hFFFD, r, -1, 0, '0, 20, got, lat, rd);
        ref_mem[16'hFFFD] = r; stored_a.push_back(16'hFFFD);
        n_checks++;
        if (!got || lat != 2) begin n_errors++; $display("FAIL mem_store_edge: got ack=%0b lat=%0d expected 1/2", got, lat); end
        do_txn(1, 1, 0, 16'hFFFD, '0, -1, 0, '0, 20, got, lat, rd);
        n_checks++;
        if (!got || rd !== r) begin n_errors++; $display("FAIL mem_load_edge: got ack=%0b d=%h expected 1/%h", got, rd, r); end
    endtask

    task automatic test_nop();
        bit got; int lat; logic [W-1:0] rd;
        do_txn(1, 0, 0, 16'hFFFF, 16'h7777, -1, 0, '0, 10, got, lat, rd);
        n_checks++;
        if (!got || lat != 1 || out_valid !== '0) begin
            n_errors++; $display("FAIL nop: got ack=%0b lat=%0d valid=%b expected 1/1/00", got, lat, out_valid);
        end
    endtask

    task automatic test_back_to_back();
        bit got; int lat; logic [W-1:0] rd; logic [W-1:0] a, b;
        out_ready = '0; a = W'($urandom); b = W'($urandom);
        do_txn(1, 0, 1, 16'hFFFF, a, -1, 0, '0, 10, got, lat, rd);
        if (got) push_exp(0, a);
        do_txn(0, 0, 1, 16'hFFFE, b, -1, 0, '0, 10, got, lat, rd);
        if (got) push_exp(1, b);
        n_checks++;
        if (!got || lat != 3) begin n_errors++; $display("FAIL back_to_back: got ack=%0b lat=%0d expected 1/3", got, lat); end
        out_ready = '1; repeat (3) @(posedge clk); #1; out_ready = '0;
    endtask

    task automatic test_random();
        bit got; int lat; logic [W-1:0] rd;
        rand_sink = 1;
        for (int i = 0; i < 80; i++) begin
            int kind, ch, dly, exp_lat;
            logic [W-1:0] a, d;
            kind = $urandom_range(0, 4);
            if (kind == 1 && stored_a.size() == 0) kind = 0;
            d = W'($urandom);
            case (kind)
                0: begin
                    a = ($urandom_range(0, 7) == 0) ? 16'hFFFD : W'($urandom_range(0, 63));
                    mem_lat = $urandom_range(0, 3);
                    do_txn(1, 1'($urandom_range(0, 1)), 1, a, d, -1, 0, '0, 30, got, lat, rd);
                    ref_mem[a] = d; stored_a.push_back(a);
                    n_checks++;
                    if (!got || lat != mem_lat + 2) begin
                        n_errors++; $display("FAIL rnd_mem_store %0d: got ack=%0b lat=%0d expected 1/%0d", i, got, lat, mem_lat + 2);
                    end
                end
                1: begin
                    a = stored_a[$urandom_range(0, stored_a.size() - 1)];
                    mem_lat = $urandom_range(0, 3);
                    do_txn(1, 1, 0, a, d, -1, 0, '0, 30, got, lat, rd);
                    n_checks++;
                    if (!got || rd !== ref_mem[a] || lat != mem_lat + 2) begin
                        n_errors++; $display("FAIL rnd_mem_load %0d: got ack=%0b d=%h lat=%0d expected 1/%h/%0d", i, got, rd, lat, ref_mem[a], mem_lat + 2);
                    end
                end
                2: begin
                    ch = $urandom_range(0, CH - 1);
                    do_txn(1, 0, 1, W'(16'hFFFF - ch), d, -1, 0, '0, 30, got, lat, rd);
                    if (got) push_exp(ch, d);
                    n_checks++;
                    if (!got) begin n_errors++; $display("FAIL rnd_io_store %0d: got no ack expected ack", i); end
                end
                3: begin
                    ch = $urandom_range(0, CH - 1); dly = $urandom_range(0, 4);
                    exp_lat = (dly + 1 > 2) ? dly + 1 : 2;
                    in_rdy_cnt[0] = 0; in_rdy_cnt[1] = 0;
                    do_txn(1, 1, 0, W'(16'hFFFF - ch), '0, ch, dly, d, 30, got, lat, rd);
                    n_checks++;
                    if (!got || rd !== d || lat != exp_lat || in_rdy_cnt[ch] != 1 || in_rdy_cnt[1-ch] != 0) begin
                        n_errors++; $display("FAIL rnd_io_load %0d: got ack=%0b d=%h lat=%0d rdy=%0d expected 1/%h/%0d/1", i, got, rd, lat, in_rdy_cnt[ch], d, exp_lat);
                    end
                end
                default: begin
                    do_txn(1, 0, 0, W'($urandom), d, -1, 0, '0, 10, got, lat, rd);
                    n_checks++;
                    if (!got || lat != 1) begin n_errors++; $display("FAIL rnd_nop %0d: got ack=%0b lat=%0d expected 1/1", i, got, lat); end
                end
            endcase
        end
        rand_sink = 0; @(posedge clk); #1;
        out_ready = '1; repeat (10) @(posedge clk); #1; out_ready = '0;
        n_checks++;
        if (exp_q0.size() + exp_q1.size() != 0 || out_valid !== '0) begin
            n_errors++; $display("FAIL rnd_drain: got left=%0d valid=%b expected 0/00", exp_q0.size() + exp_q1.size(), out_valid);
        end
    endtask

    task automatic test_halt_drain();
        bit got; int lat; logic [W-1:0] rd;
        out_ready = '0;
        do_txn(1, 0, 1, 16'hFFFF, 16'h5A5A, -1, 0, '0, 10, got, lat, rd);
        if (got) push_exp(0, 16'h5A5A);
        in_eof[1] = 1; in_valid[1] = 0;
        do_txn(1, 1, 0, 16'hFFFE, '0, -1, 0, '0, 8, got, lat, rd);
        n_checks++;
        if (got || cpu_halt !== 1'b1) begin n_errors++; $display("FAIL halt_enter: got ack=%0b halt=%b expected 0/1", got, cpu_halt); end
        cpu_req = 0;
        out_ready[0] = 1; repeat (3) @(posedge clk); #1;
        n_checks++;
        if (cpu_halt !== 1'b1 || out_valid[0] !== 1'b0) begin
            n_errors++; $display("FAIL halt_drain: got halt=%b valid=%b expected 1/0", cpu_halt, out_valid[0]);
        end
        do_txn(1, 0, 1, 16'hFFFF, 16'h1111, -1, 0, '0, 5, got, lat, rd);
        n_checks++;
        if (got || cpu_halt !== 1'b1) begin n_errors++; $display("FAIL halt_sticky: got ack=%0b halt=%b expected 0/1", got, cpu_halt); end
        cpu_req = 0; in_eof = '0; out_ready = '0;
    endtask

    task automatic test_reset_mid_mem();
        bit got; int lat; logic [W-1:0] rd;
        apply_reset();
        n_checks++;
        if (cpu_halt !== 1'b0) begin n_errors++; $display("FAIL reset_clears_halt: got %b expected 0", cpu_halt); end
        mem_lat = 100;
        do_txn(1, 1, 0, 16'h0010, '0, -1, 0, '0, 2, got, lat, rd);
        n_checks++;
        if (got || mem_req !== 1'b1) begin n_errors++; $display("FAIL mid_mem_req: got ack=%0b req=%b expected 0/1", got, mem_req); end
        areset = 0; exp_q0.delete(); exp_q1.delete();
        #1;
        n_checks++;
        if ({cpu_ack, cpu_halt, mem_req, mem_load, mem_store, in_ready, out_valid} !== '0 ||
            {cpu_rdata, mem_addr, mem_wdata, out_data} !== '0) begin
            n_errors++; $display("FAIL mid_mem_reset: got req=%b addr=%h rdata=%h expected all 0", mem_req, mem_addr, cpu_rdata);
        end
        cpu_req = 0; mem_lat = 0;
        @(posedge clk); #1 areset = 1;
        do_txn(1, 0, 0, 16'h0000, '0, -1, 0, '0, 10, got, lat, rd);
        n_checks++;
        if (!got || lat != 1) begin n_errors++; $display("FAIL post_reset_idle: got ack=%0b lat=%0d expected 1/1", got, lat); end
        do_txn(1, 1, 0, 16'h0010, '0, -1, 0, '0, 10, got, lat, rd);
        n_checks++;
        if (!got || rd !== ref_mem[16'h0010] || lat != 2) begin
            n_errors++; $display("FAIL post_reset_mem: got ack=%0b d=%h lat=%0d expected 1/%h/2", got, rd, lat, ref_mem[16'h0010]);
        end
    endtask

    initial begin
        #2000000;
        n_errors++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $fatal(1);
    end

    initial begin
        cpu_req = 0; cpu_load = 0; cpu_store = 0; cpu_addr = '0; cpu_wdata = '0;
        in_valid = '0; in_data = '0; in_eof = '0; out_ready = '0; areset = 0;
        in_rdy_cnt[0] = 0; in_rdy_cnt[1] = 0;
        test_reset();
        test_out_store();
        test_fifo_full();
        test_in_load();
        test_mem_access();
        test_nop();
        test_back_to_back();
        test_random();
        test_halt_drain();
        test_reset_mid_mem();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
